// File: rtl/sc_regmov_pkg.sv
// Shared encodings for the player-position mover.
// Imported by the repeat FSM and the position register top.
package sc_regmov_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

endpackage

// File: rtl/sc_regmov_repeat.sv
// Press/hold/auto-repeat FSM for the mover.
// Emits one step strobe per press and per repeat period.
module sc_regmov_repeat
  import sc_regmov_pkg::*;
#(
  parameter int CNTWIDTH     = 25,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 6250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic enable,
  input  dir_e dir,
  output logic step,
  output dir_e step_dir
);

  localparam logic [CNTWIDTH-1:0] DLY_LD =
    CNTWIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNTWIDTH-1:0] RATE_LD =
    CNTWIDTH'(REPEAT_RATE - 1);

  rep_state_e        state_q, state_n;
  dir_e              dir_q, dir_n;
  logic [CNTWIDTH-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    dir_n    = dir_q;
    cnt_n    = cnt_q;
    step     = 1'b0;
    step_dir = DIR_NONE;
    if (flush || !enable || dir == DIR_NONE) begin
      state_n = ST_IDLE;
      dir_n   = DIR_NONE;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        ST_FIRST, ST_REPEAT: begin
          if (dir != dir_q) begin
            // opposite direction behaves as a fresh press
            step     = 1'b1;
            step_dir = dir;
            dir_n    = dir;
            cnt_n    = DLY_LD;
            state_n  = ST_FIRST;
          end else if (cnt_q != '0) begin
            cnt_n = cnt_q - CNTWIDTH'(1);
          end else begin
            step     = 1'b1;
            step_dir = dir;
            cnt_n    = RATE_LD;
            state_n  = ST_REPEAT;
          end
        end
        default: begin
          step     = 1'b1;
          step_dir = dir;
          dir_n    = dir;
          cnt_n    = DLY_LD;
          state_n  = ST_FIRST;
        end
      endcase
    end
  end

endmodule

// File: rtl/sc_regjug_mover.sv
// One-hot player position register with edge/auto-repeat moves,
// wrap or saturate borders, sync clear and parallel load.
module sc_regjug_mover
  import sc_regmov_pkg::*;
#(
  parameter int REGMOV_DATAWIDTH = 8,
  parameter logic [REGMOV_DATAWIDTH-1:0] DATA_INIT_POS = 8'b01000000,
  parameter bit REGMOV_WRAP_EN = 1'b1,
  parameter int REGMOV_CNTWIDTH = 25,
  parameter int REGMOV_REPEAT_DELAY = 25000000,
  parameter int REGMOV_REPEAT_RATE = 6250000
) (
  input  logic SC_REGMOV_CLOCK_50,
  input  logic SC_REGMOV_RESET_InLow,
  input  logic SC_REGMOV_clear_InLow,
  input  logic SC_REGMOV_enable_In,
  input  logic SC_REGMOV_load_InLow,
  input  logic [REGMOV_DATAWIDTH-1:0] SC_REGMOV_data_InBUS,
  input  logic [1:0] SC_REGMOV_shiftselection_In,
  output logic [REGMOV_DATAWIDTH-1:0] SC_REGMOV_data_OutBUS,
  output logic SC_REGMOV_moved_Out,
  output logic SC_REGMOV_blocked_Out
);

  localparam int W = REGMOV_DATAWIDTH;

  if (REGMOV_REPEAT_DELAY < 1 || REGMOV_REPEAT_RATE < 1 ||
      longint'(REGMOV_REPEAT_DELAY) >=
        (longint'(1) << REGMOV_CNTWIDTH) ||
      longint'(REGMOV_REPEAT_RATE) >=
        (longint'(1) << REGMOV_CNTWIDTH)) begin : g_bad_cfg
    $error("sc_regjug_mover: repeat timing out of range");
  end

  dir_e   dir, step_dir;
  logic   step, flush;
  logic   border;
  logic [W-1:0] pos_q, pos_n, shifted;
  logic   moved_n, blocked_n;

  always_comb begin
    dir = DIR_NONE;
    unique case (1'b1)
      (SC_REGMOV_shiftselection_In == 2'b01): dir = DIR_LEFT;
      (SC_REGMOV_shiftselection_In == 2'b10): dir = DIR_RIGHT;
      default: dir = DIR_NONE;
    endcase
  end

  assign flush = !SC_REGMOV_clear_InLow || !SC_REGMOV_load_InLow;

  sc_regmov_repeat #(
    .CNTWIDTH    (REGMOV_CNTWIDTH),
    .REPEAT_DELAY(REGMOV_REPEAT_DELAY),
    .REPEAT_RATE (REGMOV_REPEAT_RATE)
  ) u_repeat (
    .clk     (SC_REGMOV_CLOCK_50),
    .rst_n   (SC_REGMOV_RESET_InLow),
    .flush   (flush),
    .enable  (SC_REGMOV_enable_In),
    .dir     (dir),
    .step    (step),
    .step_dir(step_dir)
  );

  always_comb begin
    shifted   = pos_q;
    border    = 1'b0;
    pos_n     = pos_q;
    moved_n   = 1'b0;
    blocked_n = 1'b0;
    if (step_dir == DIR_LEFT) begin
      shifted = {pos_q[W-2:0], pos_q[W-1]};
      border  = pos_q[W-1];
    end else begin
      shifted = {pos_q[0], pos_q[W-1:1]};
      border  = pos_q[0];
    end
    if (!SC_REGMOV_clear_InLow) begin
      pos_n = DATA_INIT_POS;
    end else if (!SC_REGMOV_load_InLow) begin
      pos_n = SC_REGMOV_data_InBUS;
    end else if (step) begin
      // saturate mode looks only at the border bit
      if (!REGMOV_WRAP_EN && border) begin
        blocked_n = 1'b1;
      end else begin
        pos_n   = shifted;
        moved_n = 1'b1;
      end
    end
  end

  always_ff @(posedge SC_REGMOV_CLOCK_50 or negedge SC_REGMOV_RESET_InLow) begin
    if (!SC_REGMOV_RESET_InLow) begin
      pos_q                 <= DATA_INIT_POS;
      SC_REGMOV_moved_Out   <= 1'b0;
      SC_REGMOV_blocked_Out <= 1'b0;
    end else begin
      pos_q                 <= pos_n;
      SC_REGMOV_moved_Out   <= moved_n;
      SC_REGMOV_blocked_Out <= blocked_n;
    end
  end

  assign SC_REGMOV_data_OutBUS = pos_q;

endmodule

// File: doc/sc_regjug_mover.md
Name: sc_regjug_mover

Overview:
- Parametrised successor of the player-position register.
- Holds a one-hot player position of configurable width.
- Moves it left/right on edge-detected requests, with hold-to-auto-repeat, selectable wrap-around or saturate-at-border mode, sync clear, and parallel load.
- Sits between the debounced button block and the game-logic comparator/LED matrix driver.

Parameters:
- REGMOV_DATAWIDTH, 8, position register width in bits.
- DATA_INIT_POS, 8'b01000000, position applied on reset and on clear (width REGMOV_DATAWIDTH).
- REGMOV_WRAP_EN, 1, 1 = rotate at borders; 0 = saturate at borders.
- REGMOV_CNTWIDTH, 25, width of the repeat counter.
- REGMOV_REPEAT_DELAY, 25000000, cycles a direction must be held after the first step before auto-repeat starts.
- REGMOV_REPEAT_RATE, 6250000, cycles between auto-repeat steps.

Ports:
- SC_REGMOV_CLOCK_50  input  1  system clock; all state updates on its rising edge.
- SC_REGMOV_RESET_InLow  input  1  asynchronous active-low reset.
- SC_REGMOV_clear_InLow  input  1  synchronous active-low re-init to DATA_INIT_POS.
- SC_REGMOV_enable_In  input  1  1 = movement allowed (game running).
- SC_REGMOV_load_InLow  input  1  synchronous active-low parallel load.
- SC_REGMOV_data_InBUS  input  REGMOV_DATAWIDTH  value loaded when load asserted.
- SC_REGMOV_shiftselection_In  input  2  01 = left, 10 = right, 00/11 = none.
- SC_REGMOV_data_OutBUS  output  REGMOV_DATAWIDTH  registered position.
- SC_REGMOV_moved_Out  output  1  one-cycle pulse in the cycle the position changes due to a move.
- SC_REGMOV_blocked_Out  output  1  one-cycle pulse when a step is refused at a border (saturate mode only).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (SC_REGMOV_RESET_InLow).
- Reset values: data_OutBUS = DATA_INIT_POS; moved_Out = 0; blocked_Out = 0; FSM = IDLE; counter = 0.
- Priority each cycle: reset > clear > load > move.
  - Clear or load: position update only; FSM -> IDLE, counter = 0, no moved pulse.
- Left step: {reg[W-2:0], reg[W-1]}.
- Right step: {reg[0], reg[W-1:1]}.
- Saturate mode (WRAP_EN = 0):
  - Left with reg[W-1] = 1, or right with reg[0] = 1: position held, blocked_Out pulses, moved_Out = 0.
  - No one-hot check is made; the border bit alone decides.
- Direction decode: dir = shiftselection when 01 or 10; otherwise NONE. 11 counts as NONE.
- FSM states and transitions:
  - IDLE:
    - dir != NONE and enable = 1: step once; load counter = REPEAT_DELAY-1; -> FIRST. Store dir.
  - FIRST:
    - dir == stored and counter != 0: decrement.
    - dir == stored and counter == 0: step; counter = REPEAT_RATE-1; -> REPEAT.
  - REPEAT:
    - dir == stored and counter != 0: decrement.
    - dir == stored and counter == 0: step; reload REPEAT_RATE-1.
  - FIRST/REPEAT, dir == NONE: -> IDLE, counter = 0, no step.
  - FIRST/REPEAT, dir changes to the opposite direction: treated as a new press in the same cycle. Step in the new direction; counter = REPEAT_DELAY-1; -> FIRST.
  - enable = 0 in any state: no step; FSM -> IDLE; counter = 0.
    - Raising enable while a button is already held produces a step on the next cycle (treated as a press).
- Latency: a press sampled at edge N shows on data_OutBUS after edge N; moved_Out is registered and high for that same cycle.
- Step timing while held: first step at the press; second step exactly REPEAT_DELAY cycles later; then one step every REPEAT_RATE cycles.
- Reset asserted mid-hold: immediate return to reset values. After release, a still-held button counts as a new press.
- Widths: the counter saturates at 0 and never underflows. REPEAT_DELAY and REPEAT_RATE must be >= 1 and fit in CNTWIDTH (checked by a generate-time assertion).

Decomposition:
- Shared package sc_regmov_pkg:
  - FSM state encoding: IDLE = 2'd0, FIRST = 2'd1, REPEAT = 2'd2.
  - Direction encoding: NONE, LEFT, RIGHT.
- One sub-module, sc_regmov_repeat: the press/hold/repeat FSM plus counter. Outputs a step strobe and direction.
- The top module keeps the position register, the shift/saturate datapath and the pulse outputs.

Test Plan (W = 8, REPEAT_DELAY = 4, REPEAT_RATE = 2, INIT = 8'h40):
- Reset release, no input -> data = 8'h40, moved = 0, blocked = 0. Assert reset mid-cycle -> data = 8'h40 immediately, without waiting for a clock edge.
- Right held 1 cycle from 8'h40 -> 8'h20 next cycle, moved pulse of 1 cycle, no further steps while held for 3 cycles.
- Left held 10 cycles from 8'h40, WRAP_EN = 1 -> 8'h80 at cycle 1, 8'h01 at cycle 5, 8'h02 at cycle 7, 8'h04 at cycle 9.
- WRAP_EN = 0, position 8'h80, left press -> data stays 8'h80, blocked = 1 for 1 cycle, moved = 0.
- Left held, switch to right at cycle 2 -> right step in that cycle; next right step 4 cycles later. Input 11 -> no step, FSM returns to IDLE.
- Load low with data_In = 8'h08 while right is held -> data = 8'h08, no step that cycle, next step after re-press. Clear low -> 8'h40. enable = 0 -> presses ignored.
